// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, 8 data bits LSB first, optional parity, one stop bit.
// Each received byte is presented on dataout with a one-clock rdsig pulse and error flags.
module uart_rx #(
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITYMODE = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] dataout,
  output logic       rdsig,
  output logic       dataerror,
  output logic       frameerror,
  output logic       idle
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAITHI
  } state_t;

  state_t     state;
  logic       rx_m;
  logic       rx_s;
  logic       rx_d;
  logic [3:0] cnt;
  logic [2:0] bitn;
  logic [7:0] shreg;
  logic       pbit;
  logic       start_edge;
  logic       parity_bad;

  assign start_edge = rx_d & ~rx_s;
  assign parity_bad = PARITY_EN & (pbit != (^shreg ^ PARITYMODE));

  // Synchronisers reset to the idle-high level so leaving reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      bitn       <= 3'd0;
      shreg      <= 8'd0;
      pbit       <= 1'b0;
      dataout    <= 8'd0;
      rdsig      <= 1'b0;
      dataerror  <= 1'b0;
      frameerror <= 1'b0;
      idle       <= 1'b0;
    end else begin
      rdsig <= 1'b0;
      case (state)
        IDLE: begin
          idle <= 1'b0;
          if (start_edge) begin
            state <= START;
            cnt   <= 4'd0;
            idle  <= 1'b1;
          end
        end
        // Start bit is re-checked at its middle to reject short glitches.
        START: begin
          if (cnt == 4'd7) begin
            cnt <= 4'd0;
            if (rx_s) begin
              state <= IDLE;
              idle  <= 1'b0;
            end else begin
              state <= DATA;
              bitn  <= 3'd0;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DATA: begin
          if (cnt == 4'd15) begin
            cnt         <= 4'd0;
            shreg[bitn] <= rx_s;
            if (bitn == 3'd7) begin
              state <= PARITY_EN ? PARITY : STOP;
            end else begin
              bitn <= bitn + 3'd1;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        PARITY: begin
          if (cnt == 4'd15) begin
            cnt   <= 4'd0;
            pbit  <= rx_s;
            state <= STOP;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        // A low stop bit (break) keeps the receiver busy until the line returns high.
        STOP: begin
          if (cnt == 4'd15) begin
            cnt        <= 4'd0;
            dataout    <= shreg;
            rdsig      <= 1'b1;
            frameerror <= ~rx_s;
            dataerror  <= parity_bad;
            if (rx_s) begin
              state <= IDLE;
              idle  <= 1'b0;
            end else begin
              state <= WAITHI;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        WAITHI: begin
          if (rx_s) begin
            state <= IDLE;
            idle  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          idle  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one instance without parity, one with even parity.
// Frames are serialised at 16 clk/bit on the falling clock edge; rdsig pulses are logged on negedge.
`timescale 1ns/1ps
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx0;
  logic       rx1;
  logic [7:0] dataout0, dataout1;
  logic       rdsig0, rdsig1;
  logic       dataerror0, dataerror1;
  logic       frameerror0, frameerror1;
  logic       idle0, idle1;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n0 = 0;
  int n1 = 0;
  int lastCyc0 = 0;
  logic [7:0] hist0 [64];
  logic [7:0] hist1 [64];
  logic prev0 = 1'b0;
  logic prev1 = 1'b0;
  logic long0 = 1'b0;
  logic long1 = 1'b0;

  uart_rx #(.PARITY_EN(1'b0), .PARITYMODE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .rx(rx0), .dataout(dataout0), .rdsig(rdsig0),
    .dataerror(dataerror0), .frameerror(frameerror0), .idle(idle0)
  );

  uart_rx #(.PARITY_EN(1'b1), .PARITYMODE(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .rx(rx1), .dataout(dataout1), .rdsig(rdsig1),
    .dataerror(dataerror1), .frameerror(frameerror1), .idle(idle1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rdsig0) begin
      if (n0 < 64) hist0[n0] = dataout0;
      n0++;
      lastCyc0 = cyc;
    end
    if (rdsig1) begin
      if (n1 < 64) hist1[n1] = dataout1;
      n1++;
    end
    if (rdsig0 && prev0) long0 = 1'b1;
    if (rdsig1 && prev1) long1 = 1'b1;
    prev0 = rdsig0;
    prev1 = rdsig1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic driveBit(input int sel, input logic b, input int len);
    if (sel == 0) rx0 = b;
    else rx1 = b;
    repeat (len) @(negedge clk);
  endtask

  task automatic applyStimulus(input int sel, input logic [7:0] data, input bit withParity,
                               input logic pbit, input logic stopVal, input int stopLen,
                               output int fallCyc);
    fallCyc = cyc;
    driveBit(sel, 1'b0, 16);
    for (int i = 0; i < 8; i++) driveBit(sel, data[i], 16);
    if (withParity) driveBit(sel, pbit, 16);
    driveBit(sel, stopVal, stopLen);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int fallCyc;
    int lat;
    logic [7:0] partial;

    rst_n = 1'b0;
    rx0 = 1'b1;
    rx1 = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset dataout", dataout0, 8'h00);
    checkOutput("reset rdsig", rdsig0, 1'b0);
    checkOutput("reset idle", idle0, 1'b0);
    checkOutput("reset flags", {dataerror0, frameerror0}, 2'b00);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Plain frame
    base = n0;
    applyStimulus(0, 8'h55, 1'b0, 1'b0, 1'b1, 16, fallCyc);
    checkOutput("t1 rdsig count", n0, base + 1);
    checkOutput("t1 dataout", hist0[base], 8'h55);
    checkOutput("t1 dataerror", dataerror0, 1'b0);
    checkOutput("t1 frameerror", frameerror0, 1'b0);
    checkOutput("t1 idle", idle0, 1'b0);
    lat = lastCyc0 - fallCyc;
    checkOutput("t1 latency 153..157", (lat >= 153 && lat <= 157), 1'b1);
    repeat (32) @(negedge clk);

    // Short start glitch
    base = n0;
    rx0 = 1'b0;
    repeat (4) @(negedge clk);
    rx0 = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("t2 idle after glitch", idle0, 1'b0);
    repeat (100) @(negedge clk);
    checkOutput("t2 no rdsig", n0, base);
    applyStimulus(0, 8'hA3, 1'b0, 1'b0, 1'b1, 16, fallCyc);
    checkOutput("t2 rdsig count", n0, base + 1);
    checkOutput("t2 dataout", hist0[base], 8'hA3);
    checkOutput("t2 frameerror", frameerror0, 1'b0);
    repeat (32) @(negedge clk);

    // Break: stop bit held low
    base = n0;
    applyStimulus(0, 8'h81, 1'b0, 1'b0, 1'b0, 40, fallCyc);
    checkOutput("t3 rdsig count", n0, base + 1);
    checkOutput("t3 dataout", hist0[base], 8'h81);
    checkOutput("t3 frameerror", frameerror0, 1'b1);
    checkOutput("t3 idle held", idle0, 1'b1);
    rx0 = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("t3 idle released", idle0, 1'b0);
    repeat (32) @(negedge clk);

    // Even parity
    base = n1;
    applyStimulus(1, 8'h07, 1'b1, 1'b1, 1'b1, 16, fallCyc);
    checkOutput("t4 rdsig count", n1, base + 1);
    checkOutput("t4 dataout", hist1[base], 8'h07);
    checkOutput("t4 good parity", dataerror1, 1'b0);
    checkOutput("t4 frameerror", frameerror1, 1'b0);
    repeat (32) @(negedge clk);
    applyStimulus(1, 8'h07, 1'b1, 1'b0, 1'b1, 16, fallCyc);
    checkOutput("t4b rdsig count", n1, base + 2);
    checkOutput("t4b dataout", hist1[base + 1], 8'h07);
    checkOutput("t4b bad parity", dataerror1, 1'b1);
    repeat (40) @(negedge clk);
    checkOutput("t4b dataerror sticky", dataerror1, 1'b1);

    // Back-to-back frames with a single stop bit
    base = n0;
    applyStimulus(0, 8'hA5, 1'b0, 1'b0, 1'b1, 16, fallCyc);
    applyStimulus(0, 8'h3C, 1'b0, 1'b0, 1'b1, 16, fallCyc);
    checkOutput("t5 rdsig count", n0, base + 2);
    checkOutput("t5 first byte", hist0[base], 8'hA5);
    checkOutput("t5 second byte", hist0[base + 1], 8'h3C);
    checkOutput("t5 flags", {dataerror0, frameerror0}, 2'b00);
    repeat (32) @(negedge clk);

    // Reset in the middle of data bit 4
    base = n0;
    partial = 8'h6B;
    driveBit(0, 1'b0, 16);
    for (int i = 0; i < 4; i++) driveBit(0, partial[i], 16);
    driveBit(0, partial[4], 8);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rx0 = 1'b1;
    checkOutput("t6 dataout", dataout0, 8'h00);
    checkOutput("t6 rdsig", rdsig0, 1'b0);
    checkOutput("t6 idle", idle0, 1'b0);
    checkOutput("t6 flags", {dataerror0, frameerror0}, 2'b00);
    checkOutput("t6 parity dut dataout", dataout1, 8'h00);
    checkOutput("t6 parity dut dataerror", dataerror1, 1'b0);
    repeat (200) @(negedge clk);
    checkOutput("t6 no rdsig", n0, base);
    applyStimulus(0, 8'h0F, 1'b0, 1'b0, 1'b1, 16, fallCyc);
    checkOutput("t6 rdsig count", n0, base + 1);
    checkOutput("t6 dataout", hist0[base], 8'h0F);
    repeat (16) @(negedge clk);

    checkOutput("rdsig single cycle", {long0, long1}, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
